clkdiv_ratio_ctrl: RTL and testbench

CLKDIV_RATIO_CTRL -- requirements
Module: clkdiv_ratio_ctrl

---
 rtl/clkdiv_ratio_ctrl.sv | 142 ++++++++++++++
 tb/tb_clkdiv_ratio_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_ratio_ctrl.sv
// Ratio-change controller for an even clock divider (divide by 2*(code+1)).
// Arbitrates two requesters and switches the code glitch-free at the end of a high phase.
module clkdiv_ratio_ctrl #(
  parameter logic [2:0] DIV_RESET = 3'b000
) (
  input  logic       clkin,
  input  logic       rstn,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] div0,
  input  logic [2:0] div1,
  output logic       ack0,
  output logic       ack1,
  output logic [2:0] divbyvalue,
  input  logic       clkout_fb,
  output logic       busy,
  output logic       sync_err,
  input  logic       err_clr
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    ACK       = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] div_q, div_d;
  logic [2:0] new_div_q, new_div_d;
  logic       gnt_q, gnt_d;
  logic       last_grant_q, last_grant_d;
  logic [2:0] mcnt_q, mcnt_d;
  logic       mclk_q, mclk_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q, busy_d;
  logic       sync_err_q, sync_err_d;

  logic       pick_s;
  logic [2:0] pick_div_s;
  logic       phase_end_s;

  // Mirror of the divider: it sees the same code the divider sees, so it tracks clkout exactly.
  always_comb begin
    mcnt_d = mcnt_q + 3'd1;
    mclk_d = mclk_q;
    if (mcnt_q == div_q) begin
      mcnt_d = 3'd0;
      mclk_d = ~mclk_q;
    end else begin
      mclk_d = mclk_q;
    end
  end

  // Last cycle of a high phase: switching here restarts the divider cleanly on a low phase.
  assign phase_end_s = (mcnt_q == div_q) && mclk_q;
  assign pick_s      = (req0 && req1) ? ~last_grant_q : req1;
  assign pick_div_s  = pick_s ? div1 : div0;

  // Controller next-state, arbitration and output decode.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    new_div_d    = new_div_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          new_div_d = pick_div_s;
          gnt_d     = pick_s;
          if (pick_div_s == div_q) begin
            state_d      = ACK;
            last_grant_d = pick_s;
          end else begin
            state_d = WAIT_EDGE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_EDGE: begin
        if (phase_end_s) begin
          div_d        = new_div_q;
          state_d      = ACK;
          last_grant_d = gnt_q;
        end else begin
          state_d = WAIT_EDGE;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Ack lands the cycle after the code update, for exactly one cycle.
    ack0_d = (state_q == ACK) && !gnt_q;
    ack1_d = (state_q == ACK) && gnt_q;
    busy_d = (state_d != IDLE);
    if (clkout_fb != mclk_q) begin
      sync_err_d = 1'b1;
    end else if (err_clr) begin
      sync_err_d = 1'b0;
    end else begin
      sync_err_d = sync_err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      div_q        <= DIV_RESET;
      new_div_q    <= 3'd0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      mcnt_q       <= 3'd0;
      mclk_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      busy_q       <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      new_div_q    <= new_div_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      mcnt_q       <= mcnt_d;
      mclk_q       <= mclk_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      busy_q       <= busy_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign divbyvalue = div_q;
  assign busy       = busy_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_clkdiv_ratio_ctrl.sv
// Bench for clkdiv_ratio_ctrl: divider plant, round-robin scoreboard, phase-width monitor.
`timescale 1ns/1ps
module tb_clkdiv_ratio_ctrl;
  localparam logic [2:0] DIV_RESET = 3'b000;

  logic       clkin = 1'b0;
  logic       rstn, req0, req1, err_clr, inv, clkout_fb;
  logic [2:0] div0, div1;
  logic       ack0, ack1, busy, sync_err;
  logic [2:0] divbyvalue;

  clkdiv_ratio_ctrl #(.DIV_RESET(DIV_RESET)) dut (
    .clkin(clkin), .rstn(rstn), .req0(req0), .req1(req1), .div0(div0), .div1(div1),
    .ack0(ack0), .ack1(ack1), .divbyvalue(divbyvalue), .clkout_fb(clkout_fb),
    .busy(busy), .sync_err(sync_err), .err_clr(err_clr)
  );

  always #5 clkin = ~clkin;

  // The even divider being controlled (plant), with an optional fault injector.
  logic [2:0] fcnt;
  logic       fclk;
  always @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      fcnt <= 3'd0;
      fclk <= 1'b0;
    end else if (fcnt == divbyvalue) begin
      fcnt <= 3'd0;
      fclk <= ~fclk;
    end else begin
      fcnt <= fcnt + 3'd1;
    end
  end
  assign clkout_fb = fclk ^ inv;

  typedef struct { logic id; logic [2:0] code; } exp_t;
  exp_t sb[$];
  int n_checks = 0, n_fail = 0;
  logic [2:0] cur_div;
  logic last_g, chk_phase;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input logic id, input logic [2:0] code);
    exp_t e;
    e.id = id;
    e.code = code;
    sb.push_back(e);
  endfunction

  // Monitor: pops the scoreboard on each ack and checks clkout phase widths.
  logic prev_fb, ph_valid;
  logic [2:0] prev_div;
  int width, ph_div;
  always @(negedge clkin) begin
    if (!rstn) begin
      ph_valid = 1'b0;
      prev_fb  = 1'b0;
      prev_div = DIV_RESET;
    end else begin
      chk("ack_onehot", ack0 & ack1, 0);
      if (ack0 || ack1) begin
        if (sb.size() == 0) chk("ack_unexpected", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_id", ack1, e.id);
          chk("ack_div", divbyvalue, e.code);
        end
      end
      if (chk_phase) begin
        chk("sync_err_quiet", sync_err, 0);
        if (divbyvalue != prev_div) chk("div_switch_at_high_end", {prev_fb, clkout_fb}, 2);
        if (clkout_fb != prev_fb) begin
          if (ph_valid) chk("phase_width", width, ph_div + 1);
          ph_valid = 1'b1;
          width    = 1;
          ph_div   = divbyvalue;
        end else width++;
      end else ph_valid = 1'b0;
      prev_fb  = clkout_fb;
      prev_div = divbyvalue;
    end
  end

  // Issue one request pattern; the reference model predicts grant order and codes.
  task automatic issue(input logic r0, input logic [2:0] c0, input logic r1, input logic [2:0] c1);
    int t, lat, old;
    logic first, exp_same;
    @(negedge clkin);
    old = cur_div;
    if (r0 && r1) begin
      first = ~last_g;
      if (!first) begin push(1'b0, c0); push(1'b1, c1); cur_div = c1; end
      else        begin push(1'b1, c1); push(1'b0, c0); cur_div = c0; end
      last_g = ~first;
    end else if (r0) begin
      push(1'b0, c0); cur_div = c0; last_g = 1'b0;
    end else begin
      push(1'b1, c1); cur_div = c1; last_g = 1'b1;
    end
    exp_same = (r0 ^ r1) && ((r0 ? c0 : c1) == old[2:0]);
    req0 = r0; div0 = c0; req1 = r1; div1 = c1;
    t = 0; lat = -1;
    while ((req0 || req1) && t < 64) begin
      @(negedge clkin);
      t++;
      if (ack0) begin req0 = 1'b0; if (lat < 0) lat = t; end
      if (ack1) begin req1 = 1'b0; if (lat < 0) lat = t; end
    end
    chk("ack_timeout", req0 | req1, 0);
    if (r0 ^ r1) begin
      if (exp_same) chk("same_code_latency", lat, 2);
      else chk("change_latency_window", int'(lat >= 3 && lat <= 2 * (old + 1) + 2), 1);
    end
  endtask

  initial begin
    int t;
    logic [2:0] nc;
    rstn = 1'b0; req0 = 1'b0; req1 = 1'b0; div0 = 3'd0; div1 = 3'd0;
    inv = 1'b0; err_clr = 1'b0; chk_phase = 1'b1;
    cur_div = DIV_RESET; last_g = 1'b1;
    repeat (2) @(negedge clkin);
    chk("rst_div", divbyvalue, DIV_RESET);
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sync_err", sync_err, 0);
    rstn = 1'b1;

    issue(1'b1, 3'd3, 1'b0, 3'd0);
    issue(1'b1, 3'd2, 1'b1, 3'd5);
    issue(1'b1, 3'd1, 1'b1, 3'd6);
    issue(1'b0, 3'd0, 1'b1, 3'd7);
    issue(1'b1, 3'd7, 1'b0, 3'd0);
    t = 0;
    while (!clkout_fb && t < 20) begin @(negedge clkin); t++; end
    chk("wait_high_phase", clkout_fb, 1);
    repeat (2) @(negedge clkin);
    issue(1'b1, 3'd0, 1'b0, 3'd0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0] pat;
      pat = 2'($urandom_range(1, 3));
      issue(pat[0], 3'($urandom_range(0, 7)), pat[1], 3'($urandom_range(0, 7)));
      repeat ($urandom_range(0, 4)) @(negedge clkin);
    end

    // Reset while a change is pending in WAIT_EDGE.
    @(negedge clkin);
    nc = cur_div + 3'd1;
    req0 = 1'b1; div0 = nc;
    @(negedge clkin);
    chk("busy_in_wait", busy, 1);
    rstn = 1'b0; req0 = 1'b0;
    sb.delete(); cur_div = DIV_RESET; last_g = 1'b1;
    #1;
    chk("midrst_div", divbyvalue, DIV_RESET);
    chk("midrst_busy", busy, 0);
    repeat (3) @(negedge clkin);
    chk("midrst_ack0", ack0, 0);
    rstn = 1'b1;
    issue(1'b1, 3'd5, 1'b0, 3'd0);
    issue(1'b0, 3'd2, 1'b1, 3'd2);

    // sync_err behaviour under an injected clkout mismatch.
    @(negedge clkin);
    chk("sync_err_idle", sync_err, 0);
    chk_phase = 1'b0;
    inv = 1'b1;
    @(negedge clkin); inv = 1'b0;
    chk("sync_err_set", sync_err, 1);
    repeat (5) @(negedge clkin);
    chk("sync_err_sticky", sync_err, 1);
    err_clr = 1'b1;
    @(negedge clkin); err_clr = 1'b0;
    chk("sync_err_clr", sync_err, 0);
    inv = 1'b1; err_clr = 1'b1;
    @(negedge clkin); inv = 1'b0; err_clr = 1'b0;
    chk("sync_err_set_wins", sync_err, 1);
    err_clr = 1'b1;
    @(negedge clkin); err_clr = 1'b0;
    chk("sync_err_clr2", sync_err, 0);
    chk_phase = 1'b1;
    repeat (20) @(negedge clkin);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
